fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction ROM.
- Owns the fetch PC and drives the ROM word address.
- Captures each returned instruction word, paired with its PC, into a small FIFO.
- Presents the FIFO head to the decode stage over a valid/ready handshake; a branch redirect flushes the queue and restarts fetch at the target.

Parameters:
- N, 32, instruction word width; matches ROM data width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 6, ROM word-address width; ROM holds 2^AW words.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  AW  ROM word address, equal to fpc[AW+1:2]; combinational from the fpc register.
- imem_q  in  N  ROM read data; combinational (same-cycle) response to imem_addr.
- redirect  in  1  branch taken; flush the queue and reload fpc.
- redirect_pc  in  64  byte-address target of the redirect.
- instr_o  out  N  instruction at the FIFO head.
- pc_o  out  64  byte PC of instr_o.
- valid_o  out  1  the FIFO head is valid.
- ready_i  in  1  decode accepts the head this cycle.
- count_o  out  $clog2(DEPTH)+1  current occupancy, for debug and verification.

Behaviour:
- Reset (async, while reset=1):
  - fpc=0, count=0, read and write pointers = 0.
  - valid_o=0, count_o=0, instr_o=0, pc_o=0, imem_addr=0.
- Handshake:
  - valid_o = (count != 0).
  - pop = valid_o & ready_i.
  - instr_o and pc_o hold stable while valid_o=1 and ready_i=0.
  - When valid_o=0, instr_o and pc_o drive 0.
- Fetch/push:
  - push = ~redirect & (count < DEPTH | pop).
  - On push, the entry {fpc, imem_q} is written at the write pointer and fpc <= fpc + 4.
  - When full and not popping, fpc holds and imem_addr stays constant.
- Occupancy:
  - count_next = count + push - pop.
  - Push and pop in the same cycle on a full FIFO is legal; count stays DEPTH.
  - Push on an empty FIFO is visible as valid_o=1 on the next cycle. There is no bypass, so fetch-to-decode latency is 1 cycle.
- Pointers: wrap modulo DEPTH.
- fpc arithmetic:
  - 64-bit, wraps modulo 2^64.
  - imem_addr wraps naturally at 2^AW words, e.g. fpc=0x100 with AW=6 gives imem_addr=0.
- Redirect (registered, takes effect next edge):
  - count <= 0, pointers <= 0.
  - fpc <= {redirect_pc[63:2], 2'b00}; the low two bits are forced to zero.
  - Any push in the redirect cycle is discarded.
  - A pop in the redirect cycle completes normally, i.e. decode did receive that head.
  - Cycle after a redirect: valid_o=0 and imem_addr = target word.
  - Two cycles after: valid_o=1 with pc_o = target.
- Back-to-back redirects: the last one wins; the queue stays empty throughout.
- Reset asserted mid-operation: immediate asynchronous clear to the reset values above; all in-flight entries are lost.
- No state machine beyond the FIFO/fpc registers. There is no separate idle state; fetch runs every cycle the queue has room.

Test Plan:
- Reset release, ROM words 0..3 = 0x8b1f03c9, 0x8b1f03e2, 0xf8000002, 0x8b010042, ready_i=1 -> valid_o first high one cycle after reset deasserts. Then one instruction per cycle: pc_o 0, 4, 8, 12 with matching words. count_o stays at 1.
- ready_i=0 held for 8 cycles -> count_o rises 1..4 and saturates at 4. imem_addr freezes at 4. pc_o=0 and instr_o=0x8b1f03c9 are stable. Raising ready_i then drains pc_o 0, 4, 8, 12, 16 in order with no gap.
- Full FIFO with ready_i=1 for one cycle -> count_o stays 4, the head advances to pc 4, and fpc advances to 20.
- redirect=1 with redirect_pc=0x1e while ready_i=1 and head pc=8 -> the pc=8 entry is consumed. Next cycle: valid_o=0, count_o=0, imem_addr=7. Following cycle: pc_o=0x1c.
- fpc=0xfc (imem_addr=63), running -> the next imem_addr is 0 and pc_o=0x100; no error is flagged.
- Reset pulsed asynchronously between edges with count_o=3 -> valid_o, count_o and imem_addr drop to 0 without waiting for a clock edge. After release, fetch restarts at pc 0.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction-fetch stage placed directly upstream of the instruction ROM.
//   It owns the fetch PC (fpc) and drives the ROM word address. Each cycle the
//   queue has room, it captures the returned word and its PC into a small
//   FIFO. The FIFO head is offered to decode over a valid/ready handshake.
//   A redirect flushes the queue and restarts fetch at the target.
//
// Ports
//   clk          in   1      clock, rising edge
//   reset        in   1      asynchronous, active-high reset
//   imem_addr    out  AW     ROM word address = fpc[AW+1:2]
//   imem_q       in   N      ROM read data, same-cycle response to imem_addr
//   redirect     in   1      branch taken: flush the queue and reload fpc
//   redirect_pc  in   64     byte-address redirect target
//   instr_o      out  N      instruction at the FIFO head (0 when not valid)
//   pc_o         out  64     byte PC of instr_o (0 when not valid)
//   valid_o      out  1      FIFO head is valid
//   ready_i      in   1      decode accepts the head this cycle
//   count_o      out  CW     current FIFO occupancy
module fetch_queue #(
  parameter int N     = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 6,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] imem_addr,
  input  logic [N-1:0]  imem_q,
  input  logic          redirect,
  input  logic [63:0]   redirect_pc,
  output logic [N-1:0]  instr_o,
  output logic [63:0]   pc_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [63:0]   r_fpc;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [N-1:0]  r_instr [DEPTH];
  logic [63:0]   r_pc    [DEPTH];

  logic w_valid;
  logic w_pop;
  logic w_push;

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & ready_i;
  // A full queue can still accept a word when the head leaves in the same
  // cycle; the freed slot is the one the write pointer already points at.
  assign w_push  = ~redirect & ((r_count < FULL) | w_pop);

  assign imem_addr = r_fpc[AW+1:2];
  assign valid_o   = w_valid;
  assign count_o   = r_count;
  assign instr_o   = w_valid ? r_instr[r_rptr] : '0;
  assign pc_o      = w_valid ? r_pc[r_rptr]    : '0;

  // Control state: fpc, occupancy and pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fpc   <= '0;
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else if (redirect) begin
      // A pop in this cycle has already been seen by decode; the flush only
      // drops what is left, so nothing else needs to happen for it here.
      r_fpc   <= redirect_pc & ~64'd3;
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) begin
        r_fpc  <= r_fpc + 64'd4;
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Entry storage needs no reset: entries are only observed through the
  // occupancy count, and outputs are forced to zero while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wptr] <= imem_q;
      r_pc[r_wptr]    <= r_fpc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int N     = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 6;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic [AW-1:0] imem_addr;
  logic [N-1:0]  imem_q;
  logic          redirect;
  logic [63:0]   redirect_pc;
  logic [N-1:0]  instr_o;
  logic [63:0]   pc_o;
  logic          valid_o;
  logic          ready_i;
  logic [CW-1:0] count_o;

  fetch_queue #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_q      (imem_q),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_o     (instr_o),
    .pc_o        (pc_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .count_o     (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rom [1 << AW];
  assign imem_q = rom[imem_addr];

  typedef struct packed {
    logic [63:0]  pc;
    logic [N-1:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] mfpc;
  int          vectors;
  int          miscompares;
  bit          chk_en;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    mfpc = '0;
  endtask

  // One clock: apply inputs, advance the model at the edge, return at negedge.
  task automatic cycle(input bit redir, input logic [63:0] rpc, input bit rdy);
    bit pop;
    bit push;
    redirect    = redir;
    redirect_pc = rpc;
    ready_i     = rdy;
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      pop  = (mq.size() != 0) && rdy;
      push = !redir && ((mq.size() < DEPTH) || pop);
      if (pop) void'(mq.pop_front());
      if (redir) begin
        mq.delete();
        mfpc = {rpc[63:2], 2'b00};
      end else if (push) begin
        mq.push_back('{pc: mfpc, instr: rom[mfpc[AW+1:2]]});
        mfpc = mfpc + 64'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2;
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid_o",   64'(valid_o),   64'(mq.size() != 0));
      chk("count_o",   64'(count_o),   64'(mq.size()));
      chk("imem_addr", 64'(imem_addr), 64'(mfpc[AW+1:2]));
      chk("pc_o",      pc_o,           (mq.size() != 0) ? mq[0].pc : 64'd0);
      chk("instr_o",   64'(instr_o),   (mq.size() != 0) ? 64'(mq[0].instr) : 64'd0);
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    chk_en      = 1'b0;
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    ready_i     = 1'b1;
    for (int i = 0; i < (1 << AW); i++) rom[i] = $urandom;
    rom[0] = 32'h8b1f03c9;
    rom[1] = 32'h8b1f03e2;
    rom[2] = 32'hf8000002;
    rom[3] = 32'h8b010042;
    model_clear();

    @(negedge clk);
    @(negedge clk);
    chk("rst valid_o",   64'(valid_o), 64'd0);
    chk("rst count_o",   64'(count_o), 64'd0);
    chk("rst imem_addr", 64'(imem_addr), 64'd0);
    chk("rst pc_o",      pc_o, 64'd0);
    chk("rst instr_o",   64'(instr_o), 64'd0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Streaming: one instruction per cycle, occupancy stays 1.
    cycle(0, 0, 1);
    chk("first valid", 64'(valid_o), 64'd1);
    chk("first instr", 64'(instr_o), 64'h8b1f03c9);
    chk("first pc",    pc_o, 64'd0);
    cycle(0, 0, 1);
    chk("s pc4",    pc_o, 64'd4);
    chk("s ins4",   64'(instr_o), 64'h8b1f03e2);
    cycle(0, 0, 1);
    chk("s pc8",    pc_o, 64'd8);
    chk("s ins8",   64'(instr_o), 64'hf8000002);
    cycle(0, 0, 1);
    chk("s pc12",   pc_o, 64'd12);
    chk("s ins12",  64'(instr_o), 64'h8b010042);
    chk("s count",  64'(count_o), 64'd1);

    // Backpressure from reset: fill to DEPTH and hold.
    pulse_reset();
    for (int k = 1; k <= 8; k++) begin
      cycle(0, 0, 0);
      chk("bp count", 64'(count_o), 64'((k < DEPTH) ? k : DEPTH));
    end
    chk("bp imem_addr", 64'(imem_addr), 64'd4);
    chk("bp pc",        pc_o, 64'd0);
    chk("bp instr",     64'(instr_o), 64'h8b1f03c9);

    // Full with a single pop: simultaneous push keeps the queue full.
    cycle(0, 0, 1);
    chk("fp count", 64'(count_o), 64'd4);
    chk("fp pc",    pc_o, 64'd4);
    chk("fp addr",  64'(imem_addr), 64'd5);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 1);
      chk("drain pc", pc_o, 64'(8 + 4 * k));
    end

    // Redirect while the pc=8 entry is being consumed.
    pulse_reset();
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    chk("pre-redir pc", pc_o, 64'd8);
    cycle(1, 64'h1e, 1);
    chk("redir valid", 64'(valid_o), 64'd0);
    chk("redir count", 64'(count_o), 64'd0);
    chk("redir addr",  64'(imem_addr), 64'd7);
    cycle(0, 0, 1);
    chk("redir pc",    pc_o, 64'h1c);

    // ROM word-address wrap.
    cycle(1, 64'hfc, 1);
    chk("wrap addr63", 64'(imem_addr), 64'd63);
    cycle(0, 0, 1);
    chk("wrap pc fc",  pc_o, 64'hfc);
    chk("wrap addr0",  64'(imem_addr), 64'd0);
    cycle(0, 0, 1);
    chk("wrap pc100",  pc_o, 64'h100);

    // Back-to-back redirects: the last wins.
    cycle(1, 64'h40, 1);
    cycle(1, 64'h83, 1);
    chk("b2b count", 64'(count_o), 64'd0);
    cycle(0, 0, 1);
    chk("b2b pc",    pc_o, 64'h80);

    // Async reset between edges with three entries in flight.
    cycle(1, 64'h0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("ar count3", 64'(count_o), 64'd3);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    chk("ar valid", 64'(valid_o), 64'd0);
    chk("ar count", 64'(count_o), 64'd0);
    chk("ar addr",  64'(imem_addr), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    cycle(0, 0, 1);
    chk("ar restart pc", pc_o, 64'd0);
    chk("ar restart v",  64'(valid_o), 64'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit          rd;
      logic [63:0] tgt;
      rd = ($urandom_range(15) == 0);
      case ($urandom_range(3))
        0:       tgt = {$urandom, $urandom};
        1:       tgt = 64'hffff_ffff_ffff_fff0 | 64'($urandom_range(15));
        default: tgt = 64'($urandom_range(511));
      endcase
      if ($urandom_range(199) == 0) pulse_reset();
      else cycle(rd, tgt, ($urandom_range(3) != 0));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
